tape_ram_loader: RTL and testbench

- Downstream stage of the cached TAP parser.
- Consumes its byte-write stream (tape_wr / tape_addr / tape_dout) plus tape_complete and loadpoint.
- Buffers bytes in a small FIFO and commits them to Oric main RAM through a req/ack port shared with the CPU memory arbiter.
- Once every byte is committed: signals load completion, and optionally requests a CPU jump to the load point (autorun).

---
 rtl/tape_ram_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_tape_ram_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_ram_loader.sv
// tape_ram_loader
// Downstream stage of the cached TAP parser. Captures the parser's byte-write
// stream, buffers it in a small FIFO and commits each byte to Oric main RAM
// through a req/ack port shared with the CPU memory arbiter. When every byte
// is committed it pulses load_done and, for load points above AUTORUN_MIN,
// requests a CPU jump to the load point.
//
// Optional build macro: TAPE_LOADER_CHECKSUM_EN adds a modulo-256 checksum
// output covering every byte committed during the current load.
//
// Ports:
//   clk, reset_n      system clock, synchronous active-low reset
//   tape_wr           upstream write strobe (level; may repeat an address)
//   tape_addr/dout    upstream target address / data byte
//   tape_complete     upstream last-byte flag
//   loadpoint         program start address from the TAP header
//   ram_req/ack       RAM write handshake (ack = accepted this cycle)
//   ram_addr/din      RAM write address / data, held while waiting for ack
//   busy              load in progress (STREAM/DRAIN/RUN)
//   overflow          sticky, a byte was dropped on a full FIFO
//   load_done         one-cycle pulse when the load is fully committed
//   run_req/pc/ack    autorun jump request, target and acknowledge
//   checksum          (TAPE_LOADER_CHECKSUM_EN only) sum of committed bytes
module tape_ram_loader #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [15:0] AUTORUN_MIN = 16'h0505
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tape_wr,
    input  logic [15:0] tape_addr,
    input  logic [7:0]  tape_dout,
    input  logic        tape_complete,
    input  logic [15:0] loadpoint,
    output logic        ram_req,
    input  logic        ram_ack,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        busy,
    output logic        overflow,
    output logic        load_done,
    output logic        run_req,
    output logic [15:0] run_pc,
    input  logic        run_ack
`ifdef TAPE_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]  checksum
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        RUN
    } state_t;

    state_t state;
    state_t next_state;

    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic        last_valid;
    logic [15:0] last_addr;

    logic accept;
    logic full;
    logic push;
    logic pop;
    logic drop;
    logic drain_done;

    // The parser holds tape_wr one extra cycle with an unchanged address;
    // comparing against the last accepted address filters that repeat.
    assign accept     = tape_wr && (!last_valid || (tape_addr != last_addr));
    assign full       = (count == FULL_COUNT);
    assign pop        = ram_req && ram_ack;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign push       = accept && (!full || pop);
    assign drop       = accept && full && !pop;
    assign drain_done = (count == '0) && !ram_req;

    // Capture filter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_valid <= 1'b0;
            last_addr  <= '0;
        end else if (accept) begin
            last_valid <= 1'b1;
            last_addr  <= tape_addr;
        end else if (state == IDLE) begin
            last_valid <= 1'b0;
        end
    end

    // FIFO storage (no reset needed; occupancy is tracked by count)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tape_addr, tape_dout};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // RAM port: the head entry stays in the FIFO until acked and is copied
    // into the output register one cycle after the port goes idle, giving
    // at most one committed byte every two clocks.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_req  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else if (pop) begin
            ram_req <= 1'b0;
        end else if (!ram_req && (count != '0)) begin
            ram_req             <= 1'b1;
            {ram_addr, ram_din} <= mem[rd_ptr];
        end
    end

    // Jump target latched alongside the completion flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_pc <= '0;
        end else if (((state == IDLE) || (state == STREAM)) && tape_complete) begin
            run_pc <= loadpoint;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (tape_complete) begin
                    next_state = DRAIN;
                end else if (accept) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (tape_complete) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    next_state = (run_pc > AUTORUN_MIN) ? RUN : IDLE;
                end
            end
            RUN: begin
                if (run_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (state != IDLE);
        run_req   = (state == RUN);
        load_done = (state == DRAIN) && drain_done;
    end

`ifdef TAPE_LOADER_CHECKSUM_EN
    // Only commits made while the load is active are summed, so the value
    // holds steady from load_done until the next load begins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if ((state == IDLE) && (next_state != IDLE)) begin
            checksum <= '0;
        end else if (pop && ((state == STREAM) || (state == DRAIN))) begin
            checksum <= checksum + ram_din;
        end
    end
`endif

endmodule

// File: tb/tb_tape_ram_loader.sv
module tb_tape_ram_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tape_wr;
    logic [15:0] tape_addr;
    logic [7:0]  tape_dout;
    logic        tape_complete;
    logic [15:0] loadpoint;
    logic        ram_req;
    logic        ram_ack;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        busy;
    logic        overflow;
    logic        load_done;
    logic        run_req;
    logic [15:0] run_pc;
    logic        run_ack;
`ifdef TAPE_LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
    logic [7:0]  cks_at_done = '0;
`endif

    always #5 clk = ~clk;

    tape_ram_loader #(
        .FIFO_DEPTH (16),
        .AUTORUN_MIN(16'h0505)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tape_wr      (tape_wr),
        .tape_addr    (tape_addr),
        .tape_dout    (tape_dout),
        .tape_complete(tape_complete),
        .loadpoint    (loadpoint),
        .ram_req      (ram_req),
        .ram_ack      (ram_ack),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .busy         (busy),
        .overflow     (overflow),
        .load_done    (load_done),
        .run_req      (run_req),
        .run_pc       (run_pc),
        .run_ack      (run_ack)
`ifdef TAPE_LOADER_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t exp_q[$];

    int unsigned errors      = 0;
    int unsigned checks      = 0;
    int unsigned writes      = 0;
    int unsigned done_pulses = 0;
    int unsigned run_seen    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted RAM write is matched against the queue
    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_req && ram_ack) begin
                writes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %h expected none", {ram_addr, ram_din});
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("ram_write", {8'h00, ram_addr, ram_din}, {8'h00, e.a, e.d});
                end
            end
            if (load_done) begin
                done_pulses++;
`ifdef TAPE_LOADER_CHECKSUM_EN
                cks_at_done = checksum;
`endif
            end
            if (run_req) begin
                run_seen++;
            end
        end
    end

    task automatic put(input logic [15:0] a, input logic [7:0] d, input logic c, input bit expect_write);
        wr_t e;
        @(posedge clk); #1;
        tape_wr       = 1'b1;
        tape_addr     = a;
        tape_dout     = d;
        tape_complete = c;
        if (expect_write) begin
            e = {a, d};
            exp_q.push_back(e);
        end
    endtask

    task automatic quiet();
        @(posedge clk); #1;
        tape_wr       = 1'b0;
        tape_complete = 1'b0;
    endtask

    task automatic complete_pulse();
        @(posedge clk); #1;
        tape_wr       = 1'b0;
        tape_complete = 1'b1;
        @(posedge clk); #1;
        tape_complete = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && !ram_req && (exp_q.size() == 0)) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    int unsigned w0;
    int unsigned d0;
    int unsigned r0;
    int unsigned lat;
    bit          stable;
    bit          seen;

    initial begin
        reset_n       = 1'b0;
        tape_wr       = 1'b0;
        tape_addr     = '0;
        tape_dout     = '0;
        tape_complete = 1'b0;
        loadpoint     = '0;
        ram_ack       = 1'b1;
        run_ack       = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {25'd0, ram_req, busy, overflow, load_done, run_req, 2'b00}, 32'd0);
        chk("reset_run_pc", {16'd0, run_pc}, 32'd0);

        // Write path, no autorun (0x0501 <= 0x0505)
        w0 = writes; d0 = done_pulses; r0 = run_seen;
        loadpoint = 16'h0501;
        put(16'h0501, 8'hAA, 1'b0, 1'b1);
        put(16'h0502, 8'hBB, 1'b0, 1'b1);
        put(16'h0503, 8'hCC, 1'b0, 1'b1);
        put(16'h0504, 8'hDD, 1'b1, 1'b1);
        quiet();
        wait_idle("t1_idle");
        chk("t1_writes", writes - w0, 32'd4);
        chk("t1_load_done", done_pulses - d0, 32'd1);
        chk("t1_no_run", run_seen - r0, 32'd0);

        // Autorun
        w0 = writes; d0 = done_pulses;
        loadpoint = 16'h0600;
        put(16'h0501, 8'hAA, 1'b0, 1'b1);
        put(16'h0502, 8'hBB, 1'b0, 1'b1);
        put(16'h0503, 8'hCC, 1'b0, 1'b1);
        put(16'h0504, 8'hDD, 1'b1, 1'b1);
        quiet();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (run_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t2_run_req_rise", {31'd0, seen}, 32'd1);
        chk("t2_writes", writes - w0, 32'd4);
        chk("t2_load_done", done_pulses - d0, 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!run_req || (run_pc != 16'h0600)) stable = 1'b0;
        end
        chk("t2_run_hold", {31'd0, stable}, 32'd1);
        @(posedge clk); #1 run_ack = 1'b1;
        @(negedge clk);
        chk("t2_ack_cycle", {14'd0, busy, run_req, run_pc}, {14'd0, 2'b11, 16'h0600});
        @(posedge clk); #1 run_ack = 1'b0;
        @(negedge clk);
        chk("t2_after_ack", {30'd0, busy, run_req}, 32'd0);

        // Duplicate filter
        w0 = writes;
        loadpoint = 16'h0100;
        put(16'h0600, 8'h5A, 1'b0, 1'b1);
        put(16'h0600, 8'h5A, 1'b0, 1'b0);
        quiet();
        complete_pulse();
        wait_idle("t3_idle");
        chk("t3_single_write", writes - w0, 32'd1);

        // Back-pressure and overflow
        w0 = writes;
        ram_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            put(16'h1000 + 16'(i), 8'(i) ^ 8'h3C, 1'b0, 1'b1);
        end
        quiet();
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ram_req || (ram_addr != 16'h1000) || (ram_din != 8'h3C)) stable = 1'b0;
        end
        chk("t4_head_stable", {31'd0, stable}, 32'd1);
        chk("t4_no_overflow", {31'd0, overflow}, 32'd0);
        put(16'h1010, 8'h77, 1'b0, 1'b0);
        quiet();
        @(negedge clk);
        chk("t4_overflow", {31'd0, overflow}, 32'd1);
        complete_pulse();
        ram_ack = 1'b1;
        wait_idle("t4_idle");
        chk("t4_writes", writes - w0, 32'd16);

        // Reset mid-load
        w0 = writes;
        ram_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            put(16'h3000 + 16'(i), 8'h80 + 8'(i), 1'b0, 1'b1);
        end
        quiet();
        ram_ack = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (writes - w0 >= 3) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_three_writes", {31'd0, seen}, 32'd1);
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("t5_after_reset", {29'd0, ram_req, busy, overflow}, 32'd0);
        exp_q.delete();
        repeat (20) @(negedge clk);
        chk("t5_no_more_writes", writes - w0, 32'd3);

        // tape_complete from IDLE, boundary load point 0x0505 (no autorun)
        d0 = done_pulses; r0 = run_seen;
        loadpoint = 16'h0505;
        complete_pulse();
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (load_done) begin
                lat = i;
                break;
            end
        end
        chk("t6_done_latency_ok", {31'd0, (lat >= 1) && (lat <= 2)}, 32'd1);
        @(negedge clk);
        chk("t6_back_idle", {30'd0, busy, run_req}, 32'd0);
        chk("t6_pulses", done_pulses - d0, 32'd1);
        chk("t6_no_run", run_seen - r0, 32'd0);

`ifdef TAPE_LOADER_CHECKSUM_EN
        loadpoint = 16'h0100;
        put(16'h2000, 8'hFF, 1'b0, 1'b1);
        put(16'h2001, 8'h02, 1'b0, 1'b1);
        put(16'h2002, 8'h10, 1'b1, 1'b1);
        quiet();
        wait_idle("t7_idle");
        chk("t7_checksum", {24'd0, cks_at_done}, 32'h11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
